channel_reduce_n: RTL and testbench

//  Parametrised channel reducer. On each start pulse, it pulls len words from

---
 rtl/chan_reduce_pkg.sv | 16 +
 rtl/channel_reduce_n_if.sv | 22 ++
 rtl/chan_reduce_op.sv | 31 +++
 rtl/channel_reduce_n.sv | 126 ++++++++++++
 tb/tb_channel_reduce_n.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/chan_reduce_pkg.sv
// Shared encodings for the channel reducer family: operator modes and FSM states.
package chan_reduce_pkg;

   localparam logic [1:0] MODE_SUM = 2'd0;
   localparam logic [1:0] MODE_MAX = 2'd1;
   localparam logic [1:0] MODE_MIN = 2'd2;
   localparam logic [1:0] MODE_XOR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/channel_reduce_n_if.sv
// FIFO channel bundle. The master is the client of the FIFO; the slave is the FIFO itself.
interface channel_reduce_n_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in_data;
   logic             read_valid;
   logic             rst;
   logic             write_valid;
   logic [WIDTH-1:0] out_data;
   logic             read_ready;
   logic             write_ready;

   modport master (
      output in_data, read_valid, rst, write_valid,
      input  out_data, read_ready, write_ready
   );

   modport slave (
      input  in_data, read_valid, rst, write_valid,
      output out_data, read_ready, write_ready
   );
endinterface

// File: rtl/chan_reduce_op.sv
// Combinational fold step: result = op(acc, x). Carry is meaningful only for SUM.
module chan_reduce_op
   import chan_reduce_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, acc_i} + {1'b0, x_i};

   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      result_o = acc_i;
      carry_o  = 1'b0;
      case (mode_i)
         MODE_SUM: {carry_o, result_o} = sum;
         // Ties keep acc: strict comparisons only.
         MODE_MAX: if ($signed(x_i) > $signed(acc_i)) result_o = x_i;
         MODE_MIN: if ($signed(x_i) < $signed(acc_i)) result_o = x_i;
         default:  result_o = acc_i ^ x_i;
      endcase
   end

endmodule

// File: rtl/channel_reduce_n.sv
// Channel reducer: on start, folds min(len, MAX_COUNT) words read from "in" with the
// selected operator and writes one result word to "out".
module channel_reduce_n
   import chan_reduce_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MAX_COUNT = 16,
   parameter int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [CW-1:0]      len_i,
   input  logic [1:0]         mode_i,
   output logic               valid_o,
   output logic               busy_o,
   output logic               overflow_o,
   channel_reduce_n_if.master in_ch,
   channel_reduce_n_if.master out_ch
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [CW-1:0]    n_q,     n_d;
   logic [1:0]       mode_q,  mode_d;
   logic             ovf_q,   ovf_d;

   logic [WIDTH-1:0] op_result;
   logic             op_carry;
   logic [CW-1:0]    len_clamped;
   logic             rd_xfer;
   logic             wr_xfer;

   chan_reduce_op #(.WIDTH(WIDTH)) u_op (
      .acc_i    (acc_q),
      .x_i      (in_ch.out_data),
      .mode_i   (mode_q),
      .result_o (op_result),
      .carry_o  (op_carry)
   );

   function automatic logic [WIDTH-1:0] identity(input logic [1:0] m);
      case (m)
         MODE_MAX: return {1'b1, {(WIDTH-1){1'b0}}};
         MODE_MIN: return {1'b0, {(WIDTH-1){1'b1}}};
         default:  return '0;
      endcase
   endfunction

   assign len_clamped = (len_i > CW'(MAX_COUNT)) ? CW'(MAX_COUNT) : len_i;
   assign rd_xfer     = in_ch.read_valid && in_ch.read_ready;
   assign wr_xfer     = out_ch.write_valid && out_ch.write_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      mode_d  = mode_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               n_d     = len_clamped;
               mode_d  = mode_i;
               acc_d   = identity(mode_i);
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (len_clamped == '0) ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            if (rd_xfer) begin
               acc_d = op_result;
               cnt_d = cnt_q + CW'(1);
               ovf_d = ovf_q | op_carry;
               if (cnt_q == n_q - CW'(1)) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wr_xfer) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         mode_q  <= MODE_SUM;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         mode_q  <= mode_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid_o    = (state_q == ST_DONE);
   assign busy_o     = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign overflow_o = ovf_q;

   assign in_ch.in_data      = '0;
   assign in_ch.read_valid   = (state_q == ST_READ);
   assign in_ch.rst          = 1'b0;
   assign in_ch.write_valid  = 1'b0;

   // acc is cleared by reset, so the result bus reads 0 out of reset.
   assign out_ch.in_data     = acc_q;
   assign out_ch.read_valid  = 1'b0;
   assign out_ch.rst         = 1'b0;
   assign out_ch.write_valid = (state_q == ST_WRITE);

   logic unused_inputs;
   assign unused_inputs = ^{in_ch.write_ready, out_ch.out_data, out_ch.read_ready};

endmodule

// File: tb/tb_channel_reduce_n.sv
// Directed bench for channel_reduce_n: producer/consumer channel models with optional stalls.
module tb_channel_reduce_n;
   import chan_reduce_pkg::*;

   localparam int WIDTH     = 32;
   localparam int MAX_COUNT = 16;
   localparam int CW        = $clog2(MAX_COUNT + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] len;
   logic [1:0]    mode;
   logic          valid, busy, overflow;

   channel_reduce_n_if #(.WIDTH(WIDTH)) in_ch ();
   channel_reduce_n_if #(.WIDTH(WIDTH)) out_ch ();

   channel_reduce_n #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .len_i      (len),
      .mode_i     (mode),
      .valid_o    (valid),
      .busy_o     (busy),
      .overflow_o (overflow),
      .in_ch      (in_ch),
      .out_ch     (out_ch)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] stim[$];
   int          idx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      start                = 1'b0;
      len                  = '0;
      mode                 = MODE_SUM;
      in_ch.out_data       = '0;
      in_ch.read_ready     = 1'b0;
      in_ch.write_ready    = 1'b0;
      out_ch.out_data      = '0;
      out_ch.read_ready    = 1'b0;
      out_ch.write_ready   = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/valid"},    valid,              0);
      check({tag, "/busy"},     busy,               0);
      check({tag, "/overflow"}, overflow,           0);
      check({tag, "/in_rv"},    in_ch.read_valid,   0);
      check({tag, "/out_wv"},   out_ch.write_valid, 0);
      check({tag, "/out_data"}, out_ch.in_data,     0);
      check({tag, "/tied"},     {in_ch.in_data[0], in_ch.rst, in_ch.write_valid,
                                 out_ch.read_valid, out_ch.rst}, 0);
   endtask

   // Runs one job against the words in stim; cycle 0 is the cycle start is driven.
   task automatic run_job(input string tag, input logic [1:0] m, input logic [CW-1:0] l,
                          input bit stall, input logic [31:0] exp_res, input logic exp_ovf,
                          input int exp_reads);
      int          cyc, reads, writes, rv_cycles;
      logic [31:0] wdata;
      bit          rr, wr;
      idx = 0; reads = 0; writes = 0; rv_cycles = 0; wdata = '0;
      @(negedge clk);
      start = 1'b1; len = l; mode = m;
      in_ch.read_ready = 1'b0; out_ch.write_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; cyc = 1;
      check({tag, "/valid_drop"}, valid, 0);
      check({tag, "/busy_c1"},    busy,  1);
      while (!valid && cyc < 300) begin
         rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         wr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx >= stim.size()) rr = 1'b0;
         in_ch.read_ready   = rr;
         in_ch.out_data     = rr ? stim[idx] : $urandom();
         out_ch.write_ready = wr;
         start = stall && busy && ($urandom_range(0, 3) == 0);
         if (start) mode = 2'($urandom_range(0, 3));
         #1;
         if (in_ch.read_valid) rv_cycles++;
         if (in_ch.read_valid && rr) begin reads++; idx++; end
         if (out_ch.write_valid && wr) begin writes++; wdata = out_ch.in_data; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; in_ch.read_ready = 1'b0; out_ch.write_ready = 1'b0;
      check({tag, "/done_in_time"}, valid, 1);
      check({tag, "/written"},  wdata,          exp_res);
      check({tag, "/held"},     out_ch.in_data, exp_res);
      check({tag, "/overflow"}, overflow,       exp_ovf);
      check({tag, "/reads"},    reads,          exp_reads);
      check({tag, "/writes"},   writes,         1);
      if (!stall) begin
         check({tag, "/latency"},   cyc,       exp_reads + 2);
         check({tag, "/rv_cycles"}, rv_cycles, exp_reads);
      end
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      #2;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      stim = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_job("sum4", MODE_SUM, 5'd4, 1'b0, 32'd10, 1'b0, 4);

      stim = '{32'hFFFF_FFFF, 32'h2};
      run_job("sum_wrap", MODE_SUM, 5'd2, 1'b0, 32'h1, 1'b1, 2);

      stim = '{32'hFFFF_FFFB, 32'd7, 32'hFFFF_FF9C};
      run_job("max3", MODE_MAX, 5'd3, 1'b0, 32'd7, 1'b0, 3);
      run_job("min3", MODE_MIN, 5'd3, 1'b0, 32'hFFFF_FF9C, 1'b0, 3);

      stim = '{32'h1234_5678, 32'hFFFF_0000};
      run_job("xor2", MODE_XOR, 5'd2, 1'b0, 32'hEDCB_5678, 1'b0, 2);

      stim.delete();
      run_job("xor0", MODE_XOR, 5'd0, 1'b0, 32'h0, 1'b0, 0);
      run_job("max0", MODE_MAX, 5'd0, 1'b0, 32'h8000_0000, 1'b0, 0);
      run_job("min0", MODE_MIN, 5'd0, 1'b0, 32'h7FFF_FFFF, 1'b0, 0);

      stim.delete();
      for (int i = 1; i <= 20; i++) stim.push_back(32'(i));
      run_job("clamp20", MODE_SUM, 5'd20, 1'b0, 32'd136, 1'b0, 16);
      run_job("stall16", MODE_SUM, 5'd16, 1'b1, 32'd136, 1'b0, 16);

      // Reset in the middle of a 4-word job, after two read transfers.
      stim = '{32'd1, 32'd2, 32'd3, 32'd4};
      @(negedge clk);
      start = 1'b1; len = 5'd4; mode = MODE_SUM;
      in_ch.read_ready = 1'b1; out_ch.write_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         in_ch.out_data = stim[c];
      end
      @(negedge clk);
      check("midjob/busy", busy, 1);
      check("midjob/acc",  out_ch.in_data, 32'd3);
      in_ch.out_data = stim[2];
      #1 rst = 1'b1;
      #1;
      check_all_zero("midjob_rst");
      in_ch.read_ready = 1'b0; out_ch.write_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("rst_held");
      rst = 1'b0;

      stim = '{32'd9, 32'd9};
      run_job("after_rst", MODE_SUM, 5'd2, 1'b0, 32'd18, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
